hilo_ctrl: RTL
==============

HILO_CTRL -- requirements
Module: hilo_ctrl

Interface
REQ-001 SHALL have port Clock  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port Reset  input  1  reset; one clock, reset is asynchronous and active-high.
REQ-003 SHALL have port ACCEn  input  1  HI/LO-class operation valid in EX1 this cycle.
REQ-004 SHALL have port Op  input  4  HI/LO operation code per REQ-013.
REQ-005 SHALL have port MulIn  input  64  product from multiplier, valid when ACCEn=1.
REQ-006 SHALL have port RsIn  input  32  source operand for MTHI/MTLO.
REQ-007 SHALL have port Freeze  input  1  pipeline freeze; holds all state, accepts no new op.
REQ-008 SHALL have port Hi  output  32  architectural HI register.
REQ-009 SHALL have port Lo  output  32  architectural LO register.
REQ-010 SHALL have port MFOut  output  32  MFHI/MFLO result.
REQ-011 SHALL have port MFValid  output  1  MFOut valid this cycle, single-cycle pulse.
REQ-012 SHALL have port StallReq  output  1  request upstream stall of EX1.

Function
REQ-013 Op encoding SHALL be: 0 MULT (load), 1 MADD (add), 2 MSUB (subtract), 3 MTHI, 4 MTLO, 5 MFHI, 6 MFLO; codes 7-15 SHALL be ignored with no state change.
REQ-014 An op SHALL be accepted only in a cycle with ACCEn=1, Freeze=0 and StallReq=0.
REQ-015 FSM states SHALL be IDLE, CAP, ACC, with IDLE as the reset state.
REQ-016 An accepted MULT/MADD/MSUB SHALL capture MulIn and Op into internal registers and move IDLE->CAP.
REQ-017 In CAP, {Hi,Lo} SHALL compute the new value per REQ-018, and the FSM SHALL move CAP->ACC.
REQ-018 The new {Hi,Lo} value SHALL be the captured product for MULT, {Hi,Lo}+product for MADD and {Hi,Lo}-product for MSUB, using 64-bit modulo-2^64 arithmetic with no saturation and no flags.
REQ-019 In ACC, the computed value SHALL be written to {Hi,Lo} at the clock edge, and the FSM SHALL move ACC->IDLE.
REQ-020 The result SHALL become visible on Hi/Lo 3 edges after acceptance.
REQ-021 A new accumulate op SHALL be accepted in the cycle the FSM returns to IDLE.
REQ-022 StallReq SHALL be 1 whenever the FSM is not IDLE and ACCEn=1, covering any op, including MF, issued into a busy unit.
REQ-023 StallReq SHALL be 0 otherwise.
REQ-024 MTHI/MTLO SHALL be accepted only in IDLE and SHALL write RsIn to Hi/Lo at the next edge, with no FSM change.
REQ-025 MFHI/MFLO SHALL be accepted only in IDLE.
REQ-026 An accepted MFHI/MFLO SHALL drive MFOut with the current Hi/Lo combinationally and assert MFValid in the same cycle, with 0-cycle latency.
REQ-027 MFOut SHALL be 0 when MFValid=0.
REQ-028 When Freeze=1, the FSM, captured operands and Hi/Lo SHALL hold.
REQ-029 When Freeze=1, MFValid SHALL be 0.
REQ-030 StallReq SHALL still follow REQ-022 and REQ-023 while Freeze=1.
REQ-031 Freeze in CAP or ACC SHALL delay the write by the number of frozen cycles; no result SHALL be lost or written twice.
REQ-032 Back-to-back MADD ops SHALL each observe the fully written {Hi,Lo} of the previous op, with no forwarding bypass.

Reset
REQ-033 Reset=1 SHALL immediately force FSM=IDLE, Hi=0, Lo=0, the captured product and op=0, MFOut=0, MFValid=0 and StallReq=0, independent of Clock.
REQ-034 Reset asserted in CAP or ACC SHALL abandon the in-flight op with no write to Hi/Lo.
REQ-035 The first op SHALL be accepted on the first rising edge after Reset deasserts.

Verification
REQ-036 Reset, then MULT with MulIn=64'h0000_0002_0000_0003 -> after 3 edges, Hi=2, Lo=3; StallReq=0 throughout.
REQ-037 From Hi=0, Lo=32'hFFFF_FFFF, MADD with MulIn=1 -> Hi=1, Lo=0 (carry across the word boundary).
REQ-038 From {Hi,Lo}=0, MSUB with MulIn=1 -> Hi=32'hFFFF_FFFF, Lo=32'hFFFF_FFFF (wrap-around).
REQ-039 MULT with MulIn=5, then MFLO with ACCEn held for the next cycles -> StallReq=1 for 2 cycles, then MFValid=1 with MFOut=5.
REQ-040 MADD accepted, Freeze=1 for 3 cycles while in CAP -> write occurs 6 edges after acceptance with the correct sum, written exactly once.
REQ-041 MTHI with RsIn=32'hDEAD_BEEF, MULT accepted, Reset pulsed in ACC -> Hi=0, Lo=0, FSM=IDLE, no later write.

Source files
------------

// File: rtl/hilo_ctrl.sv
// hilo_ctrl: HI/LO register unit with a three-state multiply-accumulate
// sequencer (IDLE -> CAP -> ACC -> IDLE) and move-to/move-from paths.
//
// Ports
//   Clock    : sole clock, rising edge
//   Reset    : asynchronous, active-high
//   ACCEn    : HI/LO-class op presented this cycle
//   Op[3:0]  : 0 MULT, 1 MADD, 2 MSUB, 3 MTHI, 4 MTLO, 5 MFHI, 6 MFLO; 7-15 ignored
//   MulIn    : 64-bit multiplier product, valid with ACCEn
//   RsIn     : source operand for MTHI/MTLO
//   Freeze   : pipeline freeze, holds every register and blocks acceptance
//   Hi, Lo   : architectural HI/LO registers
//   MFOut    : MFHI/MFLO result, zero unless MFValid
//   MFValid  : MFOut valid this cycle
//   StallReq : unit busy and an op is being presented
module hilo_ctrl (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        ACCEn,
  input  logic [3:0]  Op,
  input  logic [63:0] MulIn,
  input  logic [31:0] RsIn,
  input  logic        Freeze,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic [31:0] MFOut,
  output logic        MFValid,
  output logic        StallReq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAP  = 2'd1,
    ACC  = 2'd2
  } state_t;

  typedef enum logic [3:0] {
    OP_MULT = 4'd0,
    OP_MADD = 4'd1,
    OP_MSUB = 4'd2,
    OP_MTHI = 4'd3,
    OP_MTLO = 4'd4,
    OP_MFHI = 4'd5,
    OP_MFLO = 4'd6
  } op_t;

  state_t      state, state_d;
  op_t         op_q;
  logic [63:0] prod_q;
  logic [63:0] result_q;
  logic        accept;
  logic        is_acc_op;

  // Reset is folded in so that MFValid/StallReq drop the instant Reset rises,
  // not just once the state register has been cleared.
  assign accept    = ACCEn && !Freeze && !Reset && (state == IDLE);
  assign is_acc_op = (Op == OP_MULT) || (Op == OP_MADD) || (Op == OP_MSUB);

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state;
    StallReq = ACCEn && !Reset && (state != IDLE);
    MFValid  = 1'b0;
    MFOut    = 32'd0;
    case (state)
      IDLE: begin
        if (accept && is_acc_op) state_d = CAP;
        if (accept && (Op == OP_MFHI)) begin
          MFValid = 1'b1;
          MFOut   = Hi;
        end
        if (accept && (Op == OP_MFLO)) begin
          MFValid = 1'b1;
          MFOut   = Lo;
        end
      end
      CAP:     state_d = ACC;
      ACC:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registers update with non-blocking assignments so every flop
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      op_q     <= OP_MULT;
      prod_q   <= 64'd0;
      result_q <= 64'd0;
      Hi       <= 32'd0;
      Lo       <= 32'd0;
    end else if (!Freeze) begin
      state <= state_d;
      case (state)
        IDLE: begin
          if (accept && is_acc_op) begin
            prod_q <= MulIn;
            op_q   <= op_t'(Op);
          end
          if (accept && (Op == OP_MTHI)) Hi <= RsIn;
          if (accept && (Op == OP_MTLO)) Lo <= RsIn;
        end
        CAP: begin
          // {Hi,Lo} cannot change while busy, so the value computed here is
          // still exact when it is committed one edge later.
          case (op_q)
            OP_MADD: result_q <= {Hi, Lo} + prod_q;
            OP_MSUB: result_q <= {Hi, Lo} - prod_q;
            default: result_q <= prod_q;
          endcase
        end
        ACC: begin
          Hi <= result_q[63:32];
          Lo <= result_q[31:0];
        end
        default: ;
      endcase
    end
  end

endmodule
